// File: rtl/invaders_rom_loader.sv
// invaders_rom_loader
// Owns the shared 8 KB program ROM port. Sequences an HPS download into the
// ROM, validates the byte count, holds the 8080 in reset for a settle delay
// and then hands the port over to the CPU fetch path.

module invaders_rom_loader #(
    parameter int unsigned ADDR_W        = 13,
    parameter int unsigned ROM_SIZE      = 8192,
    parameter int unsigned RELEASE_DELAY = 16
) (
    input  logic              Clk,
    input  logic              I_RESET,
    input  logic              game_reset,
    input  logic              dn_download,
    input  logic              dn_wr,
    input  logic [15:0]       dn_addr,
    input  logic [7:0]        dn_data,
    input  logic [15:0]       cpu_addr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_din,
    output logic              mem_we,
    output logic              cpu_reset,
    output logic              dl_done,
    output logic              dl_error,
    output logic [7:0]        dl_sum
);

    // Byte counter is one bit wider than the address so a full image is
    // distinguishable from an over-full (duplicated) one.
    localparam int unsigned CNT_W = ADDR_W + 1;
    // Hold counter must represent RELEASE_DELAY-1 even when RELEASE_DELAY is 1.
    localparam int unsigned DLY_W = $clog2(RELEASE_DELAY + 1);

    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] CNT_TARGET = CNT_W'(ROM_SIZE);
    localparam logic [16:0]      ADDR_LIMIT = 17'(ROM_SIZE);
    localparam logic [DLY_W-1:0] DLY_LOAD   = DLY_W'(RELEASE_DELAY - 1);

    typedef enum logic [2:0] {
        S_EMPTY = 3'd0,
        S_LOAD  = 3'd1,
        S_CHECK = 3'd2,
        S_HOLD  = 3'd3,
        S_RUN   = 3'd4
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic [DLY_W-1:0]  r_dly;
    logic [DLY_W-1:0]  w_dly_next;
    logic [CNT_W-1:0]  r_count;
    logic [7:0]        r_sum;
    logic              r_done;
    logic              r_error;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [7:0]        r_mem_din;

    logic              w_in_range;
    logic              w_accept;
    logic              w_enter_load;
    logic              w_set_done;
    logic              w_set_error;
    logic              w_unused_cpu_hi;

    // Only the low ADDR_W bits of the CPU address reach the ROM.
    assign w_unused_cpu_hi = ^cpu_addr[15:ADDR_W];

    // Bytes beyond the image size never touch the ROM or the count.
    assign w_in_range = ({1'b0, dn_addr} < ADDR_LIMIT);

    // Next-state, hold countdown and datapath control decode.
    always_comb begin
        w_next_state = r_state;
        w_dly_next   = r_dly;
        w_accept     = 1'b0;
        w_enter_load = 1'b0;
        w_set_done   = 1'b0;
        w_set_error  = 1'b0;

        unique case (r_state)
            S_EMPTY: begin
                // Nothing to run; game_reset is meaningless without an image.
            end
            S_LOAD: begin
                // A strobe coincident with the falling download sample still lands.
                w_accept = dn_wr && w_in_range;
                if (!dn_download) begin
                    w_next_state = S_CHECK;
                end
            end
            S_CHECK: begin
                if (r_count == CNT_TARGET) begin
                    w_next_state = S_HOLD;
                    w_set_done   = 1'b1;
                    w_dly_next   = DLY_LOAD;
                end else begin
                    w_next_state = S_EMPTY;
                    w_set_error  = 1'b1;
                end
            end
            S_HOLD: begin
                if (game_reset) begin
                    w_dly_next = DLY_LOAD;
                end else if (r_dly == '0) begin
                    w_next_state = S_RUN;
                end else begin
                    w_dly_next = r_dly - DLY_W'(1);
                end
            end
            S_RUN: begin
                if (game_reset) begin
                    w_next_state = S_HOLD;
                    w_dly_next   = DLY_LOAD;
                end
            end
            default: begin
                w_next_state = S_EMPTY;
            end
        endcase

        // A new download pre-empts everything else, from any state.
        if (dn_download) begin
            w_next_state = S_LOAD;
            w_enter_load = (r_state != S_LOAD);
            w_set_done   = 1'b0;
            w_set_error  = 1'b0;
        end
    end

    // State and hold-counter registers.
    always_ff @(posedge Clk) begin
        if (I_RESET) begin
            r_state <= S_EMPTY;
            r_dly   <= '0;
        end else begin
            r_state <= w_next_state;
            r_dly   <= w_dly_next;
        end
    end

    // Registered download write path, byte count, checksum and status flags.
    always_ff @(posedge Clk) begin
        if (I_RESET) begin
            r_mem_we   <= 1'b0;
            r_mem_addr <= '0;
            r_mem_din  <= '0;
            r_count    <= '0;
            r_sum      <= '0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_mem_we <= w_accept;
            if (w_accept) begin
                r_mem_addr <= dn_addr[ADDR_W-1:0];
                r_mem_din  <= dn_data;
            end
            if (w_enter_load) begin
                r_count <= '0;
                r_sum   <= '0;
                r_done  <= 1'b0;
                r_error <= 1'b0;
            end else begin
                if (w_accept) begin
                    if (r_count != CNT_MAX) begin
                        r_count <= r_count + CNT_W'(1);
                    end
                    r_sum <= r_sum + dn_data;
                end
                if (w_set_done) begin
                    r_done <= 1'b1;
                end
                if (w_set_error) begin
                    r_error <= 1'b1;
                end
            end
        end
    end

    // In RUN the CPU drives the ROM address directly; otherwise the
    // registered download path does. mem_we is never set in RUN.
    assign mem_addr  = (r_state == S_RUN) ? cpu_addr[ADDR_W-1:0] : r_mem_addr;
    assign mem_din   = r_mem_din;
    assign mem_we    = r_mem_we;
    assign cpu_reset = (r_state != S_RUN);
    assign dl_done   = r_done;
    assign dl_error  = r_error;
    assign dl_sum    = r_sum;

endmodule

// File: tb/tb_invaders_rom_loader.sv
// Testbench for invaders_rom_loader: scoreboard of expected ROM writes
// checked by a monitor on mem_we, plus directed status/timing checks.

module tb_invaders_rom_loader;

    localparam int unsigned ADDR_W = 13;

    logic              Clk;
    logic              I_RESET;
    logic              game_reset;
    logic              dn_download;
    logic              dn_wr;
    logic [15:0]       dn_addr;
    logic [7:0]        dn_data;
    logic [15:0]       cpu_addr;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_din;
    logic              mem_we;
    logic              cpu_reset;
    logic              dl_done;
    logic              dl_error;
    logic [7:0]        dl_sum;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [7:0]        d;
    } wr_t;

    wr_t exp_q[$];
    int  n_vec  = 0;
    int  n_miss = 0;
    int  n_we   = 0;

    invaders_rom_loader #(
        .ADDR_W(13),
        .ROM_SIZE(8192),
        .RELEASE_DELAY(16)
    ) dut (
        .Clk(Clk),
        .I_RESET(I_RESET),
        .game_reset(game_reset),
        .dn_download(dn_download),
        .dn_wr(dn_wr),
        .dn_addr(dn_addr),
        .dn_data(dn_data),
        .cpu_addr(cpu_addr),
        .mem_addr(mem_addr),
        .mem_din(mem_din),
        .mem_we(mem_we),
        .cpu_reset(cpu_reset),
        .dl_done(dl_done),
        .dl_error(dl_error),
        .dl_sum(dl_sum)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Monitor: every ROM write must match the next expected write.
    always @(negedge Clk) begin
        wr_t e;
        if (mem_we === 1'b1) begin
            n_we++;
            n_vec++;
            if (exp_q.size() == 0) begin
                n_miss++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                         mem_addr, mem_din);
            end else begin
                e = exp_q.pop_front();
                if (mem_addr !== e.a || mem_din !== e.d) begin
                    n_miss++;
                    $display("FAIL rom_write: got addr 0x%0h data 0x%0h, expected addr 0x%0h data 0x%0h",
                             mem_addr, mem_din, e.a, e.d);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic wr_byte(input logic [15:0] a, input logic [7:0] d, input bit expect_wr);
        wr_t e;
        dn_wr   = 1'b1;
        dn_addr = a;
        dn_data = d;
        if (expect_wr) begin
            e.a = a[ADDR_W-1:0];
            e.d = d;
            exp_q.push_back(e);
        end
        step();
        dn_wr = 1'b0;
    endtask

    // Writes bytes 0..n-1 with data addr[7:0]^x; optional 0..3 idle before each.
    task automatic load_bytes(input int n, input bit idles, input logic [7:0] x);
        logic [15:0] a;
        for (int i = 0; i < n; i++) begin
            if (idles) begin
                repeat (i % 4) step();
            end
            a = 16'(i);
            wr_byte(a, a[7:0] ^ x, 1'b1);
        end
    endtask

    // Counts edges from the current point until cpu_reset drops (bounded).
    task automatic measure_release(input string name, input int k0, input int exp_k);
        int k;
        k = k0;
        while (cpu_reset === 1'b1 && k < 300) begin
            step();
            k++;
        end
        check(name, 32'(k), 32'(exp_k));
    endtask

    task automatic start_dl();
        dn_download = 1'b1;
        step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int we0;
        int low_cnt;
        I_RESET     = 1'b1;
        game_reset  = 1'b0;
        dn_download = 1'b0;
        dn_wr       = 1'b0;
        dn_addr     = '0;
        dn_data     = '0;
        cpu_addr    = 16'hF123;
        repeat (3) step();
        I_RESET = 1'b0;
        step();

        // Reset state
        check("rst_cpu_reset", 32'(cpu_reset), 32'h1);
        check("rst_mem_we", 32'(mem_we), 32'h0);
        check("rst_mem_addr", 32'(mem_addr), 32'h0);
        check("rst_mem_din", 32'(mem_din), 32'h0);
        check("rst_dl_done", 32'(dl_done), 32'h0);
        check("rst_dl_error", 32'(dl_error), 32'h0);
        check("rst_dl_sum", 32'(dl_sum), 32'h0);

        // Full load with 0..3 idle cycles between strobes
        we0 = n_we;
        start_dl();
        load_bytes(8192, 1'b1, 8'h00);
        dn_download = 1'b0;
        measure_release("full_release_cycles", 0, 18);
        check("full_dl_done", 32'(dl_done), 32'h1);
        check("full_dl_error", 32'(dl_error), 32'h0);
        check("full_dl_sum", 32'(dl_sum), 32'h00);
        check("full_we_count", 32'(n_we - we0), 32'd8192);
        check("run_mem_addr_passthru", 32'(mem_addr), 32'h1123);
        cpu_addr = 16'h0ABC;
        #1;
        check("run_mem_addr_passthru2", 32'(mem_addr), 32'h0ABC);
        check("run_mem_we", 32'(mem_we), 32'h0);

        // game_reset pulse of 5 samples in RUN
        game_reset = 1'b1;
        step();
        check("grst_cpu_reset_rise", 32'(cpu_reset), 32'h1);
        repeat (4) step();
        game_reset = 1'b0;
        measure_release("grst_release_cycles", 0, 16);

        // Second pulse during HOLD extends the hold
        game_reset = 1'b1;
        repeat (5) step();
        game_reset = 1'b0;
        repeat (8) step();
        check("grst_hold_still_reset", 32'(cpu_reset), 32'h1);
        game_reset = 1'b1;
        repeat (3) step();
        game_reset = 1'b0;
        measure_release("grst_extend_cycles", 0, 16);

        // I_RESET during HOLD goes to EMPTY with flags cleared
        game_reset = 1'b1;
        step();
        game_reset = 1'b0;
        step();
        I_RESET = 1'b1;
        step();
        I_RESET = 1'b0;
        check("hold_rst_dl_done", 32'(dl_done), 32'h0);
        check("hold_rst_dl_sum", 32'(dl_sum), 32'h0);
        check("hold_rst_mem_addr", 32'(mem_addr), 32'h0);
        low_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (cpu_reset !== 1'b1) low_cnt++;
        end
        check("hold_rst_cpu_low_cycles", 32'(low_cnt), 32'h0);

        // Short load: 8191 bytes
        start_dl();
        load_bytes(8191, 1'b0, 8'h00);
        dn_download = 1'b0;
        repeat (3) step();
        check("short_dl_error", 32'(dl_error), 32'h1);
        check("short_dl_done", 32'(dl_done), 32'h0);
        check("short_dl_sum", 32'(dl_sum), 32'h01);
        low_cnt = 0;
        for (int i = 0; i < 120; i++) begin
            game_reset = ((i % 20) < 5);
            step();
            if (cpu_reset !== 1'b1) low_cnt++;
        end
        game_reset = 1'b0;
        check("short_cpu_low_cycles", 32'(low_cnt), 32'h0);

        // Out-of-range extras, final byte strobed on the falling download sample
        we0 = n_we;
        start_dl();
        load_bytes(8191, 1'b0, 8'h00);
        for (int i = 0; i < 256; i++) begin
            wr_byte(16'h2000 + 16'(i), 8'hA5, 1'b0);
        end
        dn_download = 1'b0;
        wr_byte(16'h1FFF, 8'hFF, 1'b1);
        measure_release("edge_release_cycles", 1, 18);
        check("edge_dl_done", 32'(dl_done), 32'h1);
        check("edge_dl_sum", 32'(dl_sum), 32'h00);
        check("oor_we_count", 32'(n_we - we0), 32'd8192);

        // Restart mid-run
        dn_download = 1'b1;
        step();
        check("restart_cpu_reset", 32'(cpu_reset), 32'h1);
        check("restart_dl_done_clear", 32'(dl_done), 32'h0);
        we0 = n_we;
        load_bytes(8192, 1'b0, 8'h5A);
        dn_download = 1'b0;
        measure_release("restart_release_cycles", 0, 18);
        check("restart_dl_done", 32'(dl_done), 32'h1);
        check("restart_dl_sum", 32'(dl_sum), 32'h00);
        check("restart_we_count", 32'(n_we - we0), 32'd8192);

        repeat (4) step();
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/invaders_rom_loader.md
# invaders_rom_loader

Sequences the 8 KB program ROM image and arbitrates the shared ROM port inside invaders_top. The HPS download stream (dn_*) and the 8080 CPU fetch path both need that port. The block owns the port and holds the CPU in reset until a complete image has landed. It then releases the CPU after a fixed settle delay and hands the port over. It also re-sequences cleanly on a new download or a game reset.

## Interface

- ADDR_W, 13, ROM address width
- ROM_SIZE, 8192, required number of in-range bytes for a valid image
- RELEASE_DELAY, 16, cycles the CPU is held in reset after a valid image, ≥1

Ports:

- Clk  in  1  system clock (9.984 MHz domain)
- I_RESET  in  1  synchronous, active-high power-on reset
- game_reset  in  1  OSD/button reset request, level
- dn_download  in  1  download window active
- dn_wr  in  1  one-cycle byte strobe
- dn_addr  in  16  byte address
- dn_data  in  8  byte data
- cpu_addr  in  16  CPU fetch address
- mem_addr  out  ADDR_W  ROM port address
- mem_din  out  8  ROM port write data
- mem_we  out  1  ROM port write enable
- cpu_reset  out  1  CPU reset, active-high
- dl_done  out  1  last download produced a valid image
- dl_error  out  1  last download was short
- dl_sum  out  8  additive checksum of accepted bytes

## Operation

States are S_EMPTY, S_LOAD, S_CHECK, S_HOLD and S_RUN.

- **I_RESET.** State goes to S_EMPTY. The byte count, dl_sum, dl_done, dl_error, mem_we, mem_addr and mem_din all clear to 0. I_RESET does not erase ROM contents.
- **Download start.** dn_download=1 in any state goes to S_LOAD on the next edge.
  - Entering S_LOAD clears the count, dl_sum, dl_done and dl_error.
  - Download start takes priority over game_reset and the HOLD countdown.
- **S_LOAD.**
  - A byte is accepted when dn_wr=1 and dn_addr < ROM_SIZE.
  - On the next edge an accepted byte registers mem_we=1, mem_addr=dn_addr[ADDR_W-1:0] and mem_din=dn_data. The count increments, saturating at 2^(ADDR_W+1)-1. dl_sum += dn_data, mod 256.
  - A byte with dn_addr ≥ ROM_SIZE is ignored: no write, no count.
  - Duplicate addresses are counted again; there is no per-address tracking.
  - When dn_download=0, the state goes to S_CHECK. A dn_wr arriving in the same cycle as that falling sample is still accepted.
- **S_CHECK.** Lasts one cycle.
  - If count == ROM_SIZE: dl_done=1 and the state goes to S_HOLD.
  - Otherwise: dl_error=1 and the state goes to S_EMPTY.
- **S_HOLD.**
  - The down-counter is loaded with RELEASE_DELAY-1 on entry and decrements each cycle.
  - At 0 the state goes to S_RUN.
  - game_reset=1 reloads the counter.
- **S_RUN.**
  - mem_addr = cpu_addr[ADDR_W-1:0], combinational pass-through.
  - mem_we=0.
  - game_reset=1 goes to S_HOLD.
- **S_EMPTY.** Waits for a download. game_reset is ignored.
- **cpu_reset** = (state != S_RUN), decoded from the state register, so it is glitch-free.
- dn_wr outside S_LOAD is ignored.

## Timing

- Reset values: cpu_reset=1, mem_we=0, mem_addr=0, mem_din=0, dl_done=0, dl_error=0, dl_sum=0.
- dn_wr at edge t produces mem_we high for exactly one cycle, at t+1. There is no backpressure; the strobe spacing (≥1 cycle) is guaranteed upstream.
- If the last dn_download=1 sample is at cycle t, then S_CHECK is at t+1 and S_HOLD is at t+2.
- With a valid image, cpu_reset falls at t+2+RELEASE_DELAY.
- A game_reset sampled in S_RUN at cycle u raises cpu_reset at u+1. It falls RELEASE_DELAY cycles after game_reset is last sampled high.
- Handover: in S_LOAD the mem_* outputs come from the registered download path. In S_RUN they come from cpu_addr. The CPU is in reset during every non-RUN cycle, so no CPU access ever overlaps a write.
- dl_done, dl_error and dl_sum hold their values until the next S_LOAD entry or I_RESET.

## Test plan

- **Full load.** Write 8192 bytes at addresses 0..8191, data=addr[7:0], with 0–3 idle cycles between strobes, then drop dn_download.
  - dl_done=1, dl_error=0, dl_sum=0x00.
  - cpu_reset falls exactly 18 cycles after the last dn_download=1 sample.
  - mem_we pulses exactly 8192 times.
- **Short load.** Write 8191 bytes.
  - dl_error=1, dl_done=0.
  - cpu_reset stays 1 for ≥100 cycles; game_reset has no effect.
- **Out-of-range.** Full load plus 256 extra bytes at addresses 0x2000..0x20FF.
  - No mem_we for the extras; count stays 8192; dl_done=1.
- **Edge strobe.** The final byte's dn_wr coincides with the first dn_download=0 sample.
  - The byte is written; dl_done=1.
- **Restart mid-run.** In S_RUN, assert dn_download.
  - cpu_reset=1 within 1 cycle; dl_done clears.
  - A reload of 8192 bytes releases the CPU again after 18 cycles.
- **game_reset.** Pulse 5 cycles in S_RUN.
  - cpu_reset goes high the next cycle and falls 16 cycles after the pulse ends.
  - A second pulse during S_HOLD extends the hold accordingly.
  - I_RESET during S_HOLD goes to S_EMPTY with all flags cleared.
